alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- ID/EX pipeline register plus EX-stage operand forwarding for the 16-bit core. Sits directly upstream of the ALU.
- Captures decoded instructions from ID and resolves register operands against the MEM and WB result buses.
- Drives the ALU inputs Src1, Src2 and AluCtrl1. Detects load-use hazards and inserts one bubble.

Parameters:
REG_AW, 4, register index width
ZERO_REG_EN, 0, if 1, register index 0 reads as 0 and is never forwarded

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
IdValid  in  1  ID holds a valid instruction
IdRegData1  in  16  register-file read of rs1
IdRegData2  in  16  register-file read of rs2
IdImm  in  16  sign/zero-extended immediate
IdUseImm  in  1  Src2 takes the immediate
IdUseRs1  in  1  instruction reads rs1
IdUseRs2  in  1  instruction reads rs2
IdRs1  in  REG_AW  rs1 index
IdRs2  in  REG_AW  rs2 index
IdRd  in  REG_AW  destination index
IdRegWrite  in  1  writes rd
IdMemRead  in  1  load
IdMemWrite  in  1  store
IdAluCtrl  in  3  ALU operation (ALU_* codes)
Stall  in  1  downstream stall; hold EX
Flush  in  1  branch/jump flush; EX becomes bubble
MemRd  in  REG_AW  MEM-stage destination
MemFwdEn  in  1  MEM result valid for forwarding (low for loads)
MemData  in  16  MEM-stage ALU result
WbRd  in  REG_AW  WB-stage destination
WbRegWrite  in  1  WB writes WbRd
WbData  in  16  WB write data
Src1  out  16  ALU operand 1
Src2  out  16  ALU operand 2
AluCtrl1  out  3  ALU operation
ExValid  out  1  EX holds a valid instruction
ExRd  out  REG_AW  EX destination
ExRegWrite  out  1  gated by ExValid
ExMemRead  out  1  gated by ExValid
ExMemWrite  out  1  gated by ExValid
ExStoreData  out  16  forwarded rs2 value for stores
LoadUseStall  out  1  ID/IF must hold this cycle

Behaviour:
- Reset (rst low, async): every EX register field cleared. ExValid, ExRegWrite, ExMemRead, ExMemWrite = 0; ExRd = 0; AluCtrl1 = 0; Src1/Src2/ExStoreData = 0 until an instruction loads.
- Register update at the clk rising edge, in priority order:
  - Flush=1 → bubble (ExValid=0, all controls 0). Flush beats Stall and LoadUseStall.
  - Else Stall=1 → hold all fields.
  - Else LoadUseStall=1 → bubble.
  - Else load all Id* fields; ExValid ← IdValid.
- LoadUseStall (combinational) = IdValid & ExValid & ExMemRead & Stall=0 & ((IdUseRs1 & IdRs1==ExRd) | (IdUseRs2 & IdRs2==ExRd)). Suppressed when ExRd==0 and ZERO_REG_EN=1. Exactly one bubble results; the load is in WB when the consumer reaches EX.
- Operand forwarding (combinational from registered fields), for each source s = rs1, rs2:
  - MEM match (MemFwdEn & MemRd==s) → MemData.
  - Else WB match (WbRegWrite & WbRd==s) → WbData.
  - Else the registered IdRegDataN.
  - MEM has priority over WB.
  - With ZERO_REG_EN=1 and s==0, the value is 0 and no forwarding occurs.
- Forwarding applies only when the registered UseRsN is set; otherwise the registered value passes through.
- Output mapping: Src1 = fwd rs1. Src2 = ExUseImm ? ExImm : fwd rs2. ExStoreData = fwd rs2 regardless of ExUseImm.
- Latency: one cycle ID→EX. Src1/Src2 track MEM/WB bus changes combinationally within the cycle.
- Bubbles keep ExRegWrite/ExMemRead/ExMemWrite at 0. Operand values during a bubble are don't-care.
- Reset mid-operation clears state immediately, independent of clk.

Test Plan:
- Reset then ADD r1=5 (IdRegData1=5), r2=7, no hazards → next cycle Src1=5, Src2=7, AluCtrl1=ADD code, ExValid=1.
- EX operand rs1=3 with MemRd=3/MemFwdEn=1/MemData=0x1234 and WbRd=3/WbRegWrite=1/WbData=0xBEEF → Src1=0x1234. Drop MemFwdEn → Src1=0xBEEF.
- Load to r4 in EX, ID reads r4 → LoadUseStall=1 for one cycle, EX bubble (ExRegWrite=0). Next cycle the consumer enters EX; WbRd=4, WbData=0x00FF → Src1=0x00FF.
- IdUseImm=1, IdImm=0xFFF0, rs2 forwarded 0x0042 from MEM → Src2=0xFFF0, ExStoreData=0x0042.
- Stall=1 for 3 cycles with changing Id* inputs → EX fields unchanged. Flush with Stall=1 → bubble on next edge.
- Assert rst low mid-stream between clock edges → ExValid and all controls 0 immediately; first instruction after release is captured correctly.

Source files
------------

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use
// hazard detection. Feeds the ALU operands, operation and store data.
module alu_operand_stage #(
  parameter int unsigned REG_AW      = 4,
  parameter int unsigned ZERO_REG_EN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IdValid,
  input  logic [15:0]       IdRegData1,
  input  logic [15:0]       IdRegData2,
  input  logic [15:0]       IdImm,
  input  logic              IdUseImm,
  input  logic              IdUseRs1,
  input  logic              IdUseRs2,
  input  logic [REG_AW-1:0] IdRs1,
  input  logic [REG_AW-1:0] IdRs2,
  input  logic [REG_AW-1:0] IdRd,
  input  logic              IdRegWrite,
  input  logic              IdMemRead,
  input  logic              IdMemWrite,
  input  logic [2:0]        IdAluCtrl,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [REG_AW-1:0] MemRd,
  input  logic              MemFwdEn,
  input  logic [15:0]       MemData,
  input  logic [REG_AW-1:0] WbRd,
  input  logic              WbRegWrite,
  input  logic [15:0]       WbData,
  output logic [15:0]       Src1,
  output logic [15:0]       Src2,
  output logic [2:0]        AluCtrl1,
  output logic              ExValid,
  output logic [REG_AW-1:0] ExRd,
  output logic              ExRegWrite,
  output logic              ExMemRead,
  output logic              ExMemWrite,
  output logic [15:0]       ExStoreData,
  output logic              LoadUseStall
);

  localparam bit ZERO_REG = (ZERO_REG_EN != 0);

  // EX-stage registered fields
  logic              ex_valid;
  logic [15:0]       ex_data1;
  logic [15:0]       ex_data2;
  logic [15:0]       ex_imm;
  logic              ex_use_imm;
  logic              ex_use_rs1;
  logic              ex_use_rs2;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic [2:0]        ex_alu_ctrl;

  logic              load_use;
  logic              rs1_hit;
  logic              rs2_hit;
  logic              rd_forwardable;
  logic [15:0]       fwd1;
  logic [15:0]       fwd2;

  // Resolve one source operand: zero register, then MEM, then WB, then the
  // register-file value captured in ID. Unused sources pass through untouched.
  function automatic logic [15:0] resolve(
    input logic              use_rs,
    input logic [REG_AW-1:0] rs,
    input logic [15:0]       reg_val,
    input logic              mem_en,
    input logic [REG_AW-1:0] mem_rd,
    input logic [15:0]       mem_data,
    input logic              wb_en,
    input logic [REG_AW-1:0] wb_rd,
    input logic [15:0]       wb_data
  );
    logic [15:0] val;
    val = reg_val;
    if (use_rs) begin
      if (ZERO_REG && (rs == '0)) begin
        val = '0;
      end else if (mem_en && (mem_rd == rs)) begin
        val = mem_data;
      end else if (wb_en && (wb_rd == rs)) begin
        val = wb_data;
      end
    end
    return val;
  endfunction

  // Load-use hazard: ID consumer depends on a load currently in EX
  always_comb begin
    rs1_hit        = IdUseRs1 && (IdRs1 == ex_rd);
    rs2_hit        = IdUseRs2 && (IdRs2 == ex_rd);
    rd_forwardable = !(ZERO_REG && (ex_rd == '0));
    load_use       = IdValid && ex_valid && ex_mem_read && !Stall &&
                     rd_forwardable && (rs1_hit || rs2_hit);
    LoadUseStall   = load_use;
  end

  // ID/EX register: flush beats stall beats load-use bubble beats capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid     <= 1'b0;
      ex_data1     <= '0;
      ex_data2     <= '0;
      ex_imm       <= '0;
      ex_use_imm   <= 1'b0;
      ex_use_rs1   <= 1'b0;
      ex_use_rs2   <= 1'b0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_alu_ctrl  <= '0;
    end else if (Flush || load_use) begin
      // load_use is already zero while Stall is high, so this covers both
      // the flush-over-stall case and the bubble-when-not-stalled case
      ex_valid     <= 1'b0;
      ex_use_imm   <= 1'b0;
      ex_use_rs1   <= 1'b0;
      ex_use_rs2   <= 1'b0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_alu_ctrl  <= '0;
    end else if (!Stall) begin
      ex_valid     <= IdValid;
      ex_data1     <= IdRegData1;
      ex_data2     <= IdRegData2;
      ex_imm       <= IdImm;
      ex_use_imm   <= IdUseImm;
      ex_use_rs1   <= IdUseRs1;
      ex_use_rs2   <= IdUseRs2;
      ex_rs1       <= IdRs1;
      ex_rs2       <= IdRs2;
      ex_rd        <= IdRd;
      ex_reg_write <= IdRegWrite;
      ex_mem_read  <= IdMemRead;
      ex_mem_write <= IdMemWrite;
      ex_alu_ctrl  <= IdAluCtrl;
    end
  end

  // Operand forwarding and output mapping
  always_comb begin
    fwd1 = resolve(ex_use_rs1, ex_rs1, ex_data1, MemFwdEn, MemRd, MemData,
                   WbRegWrite, WbRd, WbData);
    fwd2 = resolve(ex_use_rs2, ex_rs2, ex_data2, MemFwdEn, MemRd, MemData,
                   WbRegWrite, WbRd, WbData);
    Src1        = fwd1;
    Src2        = ex_use_imm ? ex_imm : fwd2;
    ExStoreData = fwd2;
    AluCtrl1    = ex_alu_ctrl;
    ExValid     = ex_valid;
    ExRd        = ex_rd;
    ExRegWrite  = ex_valid && ex_reg_write;
    ExMemRead   = ex_valid && ex_mem_read;
    ExMemWrite  = ex_valid && ex_mem_write;
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed sequences, a forwarding vector table
// and a randomized run against a cycle-level reference model.
module tb_alu_operand_stage;

  localparam int unsigned AW = 4;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;

  logic          clk = 1'b0;
  logic          rst;
  logic          IdValid;
  logic [15:0]   IdRegData1, IdRegData2, IdImm;
  logic          IdUseImm, IdUseRs1, IdUseRs2;
  logic [AW-1:0] IdRs1, IdRs2, IdRd;
  logic          IdRegWrite, IdMemRead, IdMemWrite;
  logic [2:0]    IdAluCtrl;
  logic          Stall, Flush;
  logic [AW-1:0] MemRd;
  logic          MemFwdEn;
  logic [15:0]   MemData;
  logic [AW-1:0] WbRd;
  logic          WbRegWrite;
  logic [15:0]   WbData;

  logic [15:0]   Src1, Src2, ExStoreData;
  logic [2:0]    AluCtrl1;
  logic          ExValid, ExRegWrite, ExMemRead, ExMemWrite, LoadUseStall;
  logic [AW-1:0] ExRd;

  logic [15:0]   z_Src1, z_Src2, z_ExStoreData;
  logic [2:0]    z_AluCtrl1;
  logic          z_ExValid, z_ExRegWrite, z_ExMemRead, z_ExMemWrite, z_LoadUseStall;
  logic [AW-1:0] z_ExRd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.REG_AW(AW), .ZERO_REG_EN(0)) u_dut (
    .clk(clk), .rst(rst), .IdValid(IdValid), .IdRegData1(IdRegData1),
    .IdRegData2(IdRegData2), .IdImm(IdImm), .IdUseImm(IdUseImm),
    .IdUseRs1(IdUseRs1), .IdUseRs2(IdUseRs2), .IdRs1(IdRs1), .IdRs2(IdRs2),
    .IdRd(IdRd), .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead),
    .IdMemWrite(IdMemWrite), .IdAluCtrl(IdAluCtrl), .Stall(Stall),
    .Flush(Flush), .MemRd(MemRd), .MemFwdEn(MemFwdEn), .MemData(MemData),
    .WbRd(WbRd), .WbRegWrite(WbRegWrite), .WbData(WbData), .Src1(Src1),
    .Src2(Src2), .AluCtrl1(AluCtrl1), .ExValid(ExValid), .ExRd(ExRd),
    .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite),
    .ExStoreData(ExStoreData), .LoadUseStall(LoadUseStall)
  );

  alu_operand_stage #(.REG_AW(AW), .ZERO_REG_EN(1)) u_dut_z (
    .clk(clk), .rst(rst), .IdValid(IdValid), .IdRegData1(IdRegData1),
    .IdRegData2(IdRegData2), .IdImm(IdImm), .IdUseImm(IdUseImm),
    .IdUseRs1(IdUseRs1), .IdUseRs2(IdUseRs2), .IdRs1(IdRs1), .IdRs2(IdRs2),
    .IdRd(IdRd), .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead),
    .IdMemWrite(IdMemWrite), .IdAluCtrl(IdAluCtrl), .Stall(Stall),
    .Flush(Flush), .MemRd(MemRd), .MemFwdEn(MemFwdEn), .MemData(MemData),
    .WbRd(WbRd), .WbRegWrite(WbRegWrite), .WbData(WbData), .Src1(z_Src1),
    .Src2(z_Src2), .AluCtrl1(z_AluCtrl1), .ExValid(z_ExValid), .ExRd(z_ExRd),
    .ExRegWrite(z_ExRegWrite), .ExMemRead(z_ExMemRead), .ExMemWrite(z_ExMemWrite),
    .ExStoreData(z_ExStoreData), .LoadUseStall(z_LoadUseStall)
  );

  typedef struct {
    logic          valid;
    logic [15:0]   d1, d2, imm;
    logic          use_imm, u1, u2;
    logic [AW-1:0] rs1, rs2, rd;
    logic          rw, mr, mw;
    logic [2:0]    alu;
  } id_t;

  typedef struct {
    logic [AW-1:0] mem_rd;
    logic          mem_en;
    logic [15:0]   mem_data;
    logic [AW-1:0] wb_rd;
    logic          wb_en;
    logic [15:0]   wb_data;
    logic [15:0]   exp_src1, exp_src2, exp_store;
  } fwd_vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic id_t nop();
    id_t x;
    x = '{valid: 1'b0, d1: 16'h0, d2: 16'h0, imm: 16'h0, use_imm: 1'b0,
          u1: 1'b0, u2: 1'b0, rs1: '0, rs2: '0, rd: '0, rw: 1'b0, mr: 1'b0,
          mw: 1'b0, alu: 3'd0};
    return x;
  endfunction

  task automatic drive_id(input id_t i);
    IdValid = i.valid; IdRegData1 = i.d1; IdRegData2 = i.d2; IdImm = i.imm;
    IdUseImm = i.use_imm; IdUseRs1 = i.u1; IdUseRs2 = i.u2;
    IdRs1 = i.rs1; IdRs2 = i.rs2; IdRd = i.rd;
    IdRegWrite = i.rw; IdMemRead = i.mr; IdMemWrite = i.mw; IdAluCtrl = i.alu;
  endtask

  task automatic bus_off();
    MemRd = '0; MemFwdEn = 1'b0; MemData = 16'h0;
    WbRd = '0; WbRegWrite = 1'b0; WbData = 16'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: EX contents as a plain record
  typedef struct {
    logic          valid;
    logic          known;
    id_t           f;
  } model_t;

  model_t m;

  function automatic logic [15:0] ref_operand(input logic use_rs, input logic [AW-1:0] rs,
                                              input logic [15:0] raw);
    if (!use_rs) return raw;
    if (MemFwdEn && MemRd == rs) return MemData;
    if (WbRegWrite && WbRd == rs) return WbData;
    return raw;
  endfunction

  function automatic logic ref_hazard();
    logic dep;
    dep = (IdUseRs1 && IdRs1 == m.f.rd) || (IdUseRs2 && IdRs2 == m.f.rd);
    return IdValid && m.valid && m.f.mr && !Stall && dep;
  endfunction

  fwd_vec_t vecs[8];
  id_t      ins;
  logic     exp_lus;
  logic [15:0] exp_op2;

  initial begin
    rst = 1'b0;
    Stall = 1'b0;
    Flush = 1'b0;
    drive_id(nop());
    bus_off();

    // ---- reset state ----
    #3;
    chk("rst_valid", ExValid, 0);
    chk("rst_rw", ExRegWrite, 0);
    chk("rst_mr", ExMemRead, 0);
    chk("rst_mw", ExMemWrite, 0);
    chk("rst_rd", ExRd, 0);
    chk("rst_alu", AluCtrl1, 0);
    chk("rst_src1", Src1, 0);
    chk("rst_src2", Src2, 0);
    chk("rst_store", ExStoreData, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tick();

    // ---- basic ADD, no hazards ----
    ins = nop();
    ins.valid = 1; ins.d1 = 16'd5; ins.d2 = 16'd7; ins.u1 = 1; ins.u2 = 1;
    ins.rs1 = 4'd1; ins.rs2 = 4'd2; ins.rd = 4'd3; ins.rw = 1; ins.alu = ALU_ADD;
    drive_id(ins);
    tick();
    chk("add_src1", Src1, 16'd5);
    chk("add_src2", Src2, 16'd7);
    chk("add_alu", AluCtrl1, ALU_ADD);
    chk("add_valid", ExValid, 1);
    chk("add_rw", ExRegWrite, 1);
    chk("add_rd", ExRd, 3);

    // ---- forwarding table (EX held by Stall) ----
    ins = nop();
    ins.valid = 1; ins.d1 = 16'h1111; ins.d2 = 16'h2222; ins.u1 = 1; ins.u2 = 1;
    ins.rs1 = 4'd3; ins.rs2 = 4'd5; ins.rd = 4'd6; ins.rw = 1; ins.alu = ALU_SUB;
    drive_id(ins);
    tick();
    Stall = 1'b1;
    drive_id(nop());
    vecs[0] = '{4'd3, 1'b1, 16'h1234, 4'd3, 1'b1, 16'hBEEF, 16'h1234, 16'h2222, 16'h2222};
    vecs[1] = '{4'd3, 1'b0, 16'h1234, 4'd3, 1'b1, 16'hBEEF, 16'hBEEF, 16'h2222, 16'h2222};
    vecs[2] = '{4'd5, 1'b1, 16'hAAAA, 4'd5, 1'b1, 16'hBBBB, 16'h1111, 16'hAAAA, 16'hAAAA};
    vecs[3] = '{4'd5, 1'b0, 16'hAAAA, 4'd5, 1'b1, 16'hBBBB, 16'h1111, 16'hBBBB, 16'hBBBB};
    vecs[4] = '{4'd3, 1'b1, 16'h0101, 4'd5, 1'b1, 16'h0202, 16'h0101, 16'h0202, 16'h0202};
    vecs[5] = '{4'd3, 1'b0, 16'h0101, 4'd5, 1'b0, 16'h0202, 16'h1111, 16'h2222, 16'h2222};
    vecs[6] = '{4'd4, 1'b1, 16'h0101, 4'd2, 1'b1, 16'h0202, 16'h1111, 16'h2222, 16'h2222};
    vecs[7] = '{4'd0, 1'b0, 16'h0000, 4'd3, 1'b0, 16'h9999, 16'h1111, 16'h2222, 16'h2222};
    for (int i = 0; i < 8; i++) begin
      MemRd = vecs[i].mem_rd; MemFwdEn = vecs[i].mem_en; MemData = vecs[i].mem_data;
      WbRd = vecs[i].wb_rd; WbRegWrite = vecs[i].wb_en; WbData = vecs[i].wb_data;
      #2;
      chk($sformatf("fwd%0d_src1", i), Src1, vecs[i].exp_src1);
      chk($sformatf("fwd%0d_src2", i), Src2, vecs[i].exp_src2);
      chk($sformatf("fwd%0d_store", i), ExStoreData, vecs[i].exp_store);
    end
    tick();
    Stall = 1'b0;
    bus_off();

    // ---- immediate operand vs store data; unused rs1 not forwarded ----
    ins = nop();
    ins.valid = 1; ins.use_imm = 1; ins.imm = 16'hFFF0; ins.u2 = 1; ins.rs2 = 4'd7;
    ins.d2 = 16'h9999; ins.rs1 = 4'd7; ins.d1 = 16'h3333; ins.mw = 1; ins.alu = ALU_ADD;
    drive_id(ins);
    MemRd = 4'd7; MemFwdEn = 1'b1; MemData = 16'h0042;
    tick();
    chk("imm_src2", Src2, 16'hFFF0);
    chk("imm_store", ExStoreData, 16'h0042);
    chk("imm_src1_nouse", Src1, 16'h3333);
    chk("imm_mw", ExMemWrite, 1);
    bus_off();

    // ---- load-use hazard ----
    ins = nop();
    ins.valid = 1; ins.mr = 1; ins.rw = 1; ins.rd = 4'd4; ins.u1 = 1; ins.rs1 = 4'd1;
    ins.d1 = 16'h0100; ins.alu = ALU_ADD;
    drive_id(ins);
    tick();
    chk("ld_mr", ExMemRead, 1);
    ins = nop();
    ins.valid = 1; ins.u1 = 1; ins.rs1 = 4'd4; ins.d1 = 16'hDEAD; ins.rd = 4'd5;
    ins.rw = 1; ins.alu = ALU_ADD;
    drive_id(ins);
    #1;
    chk("lus_on", LoadUseStall, 1);
    tick();
    chk("lus_bubble_valid", ExValid, 0);
    chk("lus_bubble_rw", ExRegWrite, 0);
    chk("lus_bubble_mr", ExMemRead, 0);
    chk("lus_off", LoadUseStall, 0);
    WbRd = 4'd4; WbRegWrite = 1'b1; WbData = 16'h00FF;
    tick();
    chk("lus_wb_src1", Src1, 16'h00FF);
    chk("lus_consumer_valid", ExValid, 1);
    chk("lus_consumer_rd", ExRd, 5);
    bus_off();

    // ---- stall holds EX; flush beats stall ----
    Stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      ins = nop();
      ins.valid = 1; ins.d1 = 16'($urandom); ins.u1 = 1; ins.rs1 = 4'($urandom_range(15, 0));
      ins.rd = 4'd9; ins.mw = 1; ins.alu = 3'd7;
      drive_id(ins);
      tick();
      chk($sformatf("stall%0d_rd", c), ExRd, 5);
      chk($sformatf("stall%0d_alu", c), AluCtrl1, ALU_ADD);
      chk($sformatf("stall%0d_src1", c), Src1, 16'hDEAD);
      chk($sformatf("stall%0d_mw", c), ExMemWrite, 0);
      chk($sformatf("stall%0d_rw", c), ExRegWrite, 1);
    end
    Flush = 1'b1;
    tick();
    chk("flush_valid", ExValid, 0);
    chk("flush_rw", ExRegWrite, 0);
    chk("flush_alu", AluCtrl1, 0);
    Flush = 1'b0;
    Stall = 1'b0;

    // ---- asynchronous reset mid-stream ----
    ins = nop();
    ins.valid = 1; ins.mw = 1; ins.rw = 1; ins.rd = 4'd9; ins.alu = 3'd5;
    ins.u1 = 1; ins.rs1 = 4'd2; ins.d1 = 16'h4444;
    drive_id(ins);
    tick();
    chk("pre_rst_mw", ExMemWrite, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", ExValid, 0);
    chk("arst_mw", ExMemWrite, 0);
    chk("arst_rw", ExRegWrite, 0);
    chk("arst_alu", AluCtrl1, 0);
    chk("arst_src1", Src1, 0);
    @(negedge clk);
    rst = 1'b1;
    ins = nop();
    ins.valid = 1; ins.d1 = 16'h7777; ins.u1 = 1; ins.rs1 = 4'd1; ins.rd = 4'd2;
    ins.rw = 1; ins.alu = 3'd1;
    drive_id(ins);
    tick();
    chk("post_rst_src1", Src1, 16'h7777);
    chk("post_rst_valid", ExValid, 1);
    chk("post_rst_rd", ExRd, 2);

    // ---- zero register handling (ZERO_REG_EN=0 vs 1) ----
    ins = nop();
    ins.valid = 1; ins.u1 = 1; ins.rs1 = 4'd0; ins.d1 = 16'h5555;
    ins.u2 = 1; ins.rs2 = 4'd1; ins.d2 = 16'h6666; ins.rd = 4'd3; ins.rw = 1;
    drive_id(ins);
    MemRd = 4'd0; MemFwdEn = 1'b1; MemData = 16'hAAAA;
    tick();
    chk("r0_fwd_plain", Src1, 16'hAAAA);
    chk("r0_zero_z", z_Src1, 16'h0000);
    chk("r0_rs2_z", z_Src2, 16'h6666);
    bus_off();
    ins = nop();
    ins.valid = 1; ins.mr = 1; ins.rw = 1; ins.rd = 4'd0;
    drive_id(ins);
    tick();
    ins = nop();
    ins.valid = 1; ins.u1 = 1; ins.rs1 = 4'd0; ins.rd = 4'd1; ins.rw = 1;
    drive_id(ins);
    #1;
    chk("r0_lus_plain", LoadUseStall, 1);
    chk("r0_lus_z", z_LoadUseStall, 0);
    drive_id(nop());
    tick();

    // ---- randomized run against the reference model ----
    rst = 1'b0;
    #2;
    @(negedge clk);
    rst = 1'b1;
    m.valid = 1'b0;
    m.known = 1'b0;
    m.f = nop();
    tick();
    for (int cyc = 0; cyc < 400; cyc++) begin
      ins.valid   = ($urandom_range(9, 0) < 8);
      ins.d1      = 16'($urandom);
      ins.d2      = 16'($urandom);
      ins.imm     = 16'($urandom);
      ins.use_imm = ($urandom_range(3, 0) == 0);
      ins.u1      = ($urandom_range(3, 0) != 0);
      ins.u2      = ($urandom_range(1, 0) == 0);
      ins.rs1     = 4'($urandom_range(3, 0));
      ins.rs2     = 4'($urandom_range(3, 0));
      ins.rd      = 4'($urandom_range(3, 0));
      ins.rw      = ($urandom_range(1, 0) == 0);
      ins.mr      = ($urandom_range(9, 0) < 3);
      ins.mw      = ($urandom_range(9, 0) < 2);
      ins.alu     = 3'($urandom_range(7, 0));
      drive_id(ins);
      Stall      = ($urandom_range(19, 0) < 3);
      Flush      = ($urandom_range(19, 0) < 2);
      MemRd      = 4'($urandom_range(3, 0));
      MemFwdEn   = ($urandom_range(1, 0) == 0);
      MemData    = 16'($urandom);
      WbRd       = 4'($urandom_range(3, 0));
      WbRegWrite = ($urandom_range(1, 0) == 0);
      WbData     = 16'($urandom);
      #3;
      exp_lus = ref_hazard();
      chk("rnd_lus", LoadUseStall, exp_lus);
      chk("rnd_valid", ExValid, m.valid);
      chk("rnd_rd", ExRd, m.f.rd);
      chk("rnd_alu", AluCtrl1, m.f.alu);
      chk("rnd_rw", ExRegWrite, m.valid & m.f.rw);
      chk("rnd_mr", ExMemRead, m.valid & m.f.mr);
      chk("rnd_mw", ExMemWrite, m.valid & m.f.mw);
      if (m.known) begin
        exp_op2 = ref_operand(m.f.u2, m.f.rs2, m.f.d2);
        chk("rnd_src1", Src1, ref_operand(m.f.u1, m.f.rs1, m.f.d1));
        chk("rnd_src2", Src2, m.f.use_imm ? m.f.imm : exp_op2);
        chk("rnd_store", ExStoreData, exp_op2);
      end
      @(posedge clk);
      if (Flush || exp_lus) begin
        m.valid = 1'b0;
        m.known = 1'b0;
        m.f = nop();
      end else if (!Stall) begin
        m.valid = IdValid;
        m.known = 1'b1;
        m.f = ins;
      end
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
